// File: rtl/scroll_loop_sequencer_if.sv
// Control and status bundle between the scroll sequencer and its neighbours.
// The master drives the run/speed/step controls; the slave is the sequencer.
interface scroll_loop_sequencer_if #(
  parameter int POS_W = 5
) ();
  logic             run_en;
  logic [1:0]       speed_sel;
  logic             step_req;
  logic [POS_W-1:0] scroll_pos;
  logic             scroll_tick;
  logic             loop_start;
  logic [3:0]       loop_count;
  logic             running;

  modport master (
    output run_en, speed_sel, step_req,
    input  scroll_pos, scroll_tick, loop_start, loop_count, running
  );

  modport slave (
    input  run_en, speed_sel, step_req,
    output scroll_pos, scroll_tick, loop_start, loop_count, running
  );
endinterface

// File: rtl/scroll_loop_sequencer.sv
// Scroll timing stage: prescales clk into scroll ticks, steps the phrase position
// and pulses loop_start at the start of every phrase loop (drives the LED stage enable).
module scroll_loop_sequencer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int PHRASE_LEN = 16,
  parameter int POS_W      = 5,
  parameter int DIV_W      = 25
) (
  input logic                    clk,
  input logic                    reset,
  scroll_loop_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(TICK_DIV);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PHRASE_LEN - 1);

  state_t           state_reg;
  logic [DIV_W-1:0] presc_reg;
  logic [1:0]       speed_reg;
  logic [POS_W-1:0] pos_reg;
  logic [3:0]       loop_count_reg;
  logic             tick_reg;
  logic             loop_start_reg;
  logic             running_reg;

  // Terminal prescaler value for each speed setting: (TICK_DIV >> speed) - 1.
  logic [DIV_W-1:0] term_tbl [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_term
      assign term_tbl[gi] = (DIV_FULL >> gi) - DIV_W'(1);
    end
  endgenerate

  logic             speed_change;
  logic [DIV_W-1:0] term_count;
  logic             at_terminal;
  logic             count_en;
  logic             advance;
  logic             pos_last;

  always_comb begin
    speed_change = (bus.speed_sel != speed_reg);
    term_count   = term_tbl[speed_reg];
    // >= so a prescaler left above a shorter period still produces a tick.
    at_terminal  = (presc_reg >= term_count);
    // HOLD->RUN edge already counts, so the prescaler resumes without a lost cycle.
    count_en     = (state_reg != IDLE) && bus.run_en;
    advance      = (count_en && !speed_change && at_terminal) ||
                   ((state_reg == HOLD) && !bus.run_en && bus.step_req);
    pos_last     = (pos_reg == POS_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      speed_reg      <= bus.speed_sel;
      pos_reg        <= '0;
      loop_count_reg <= '0;
      tick_reg       <= 1'b0;
      loop_start_reg <= 1'b0;
      running_reg    <= 1'b0;
    end else begin
      speed_reg      <= bus.speed_sel;
      tick_reg       <= 1'b0;
      loop_start_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.run_en) begin
            state_reg      <= RUN;
            running_reg    <= 1'b1;
            loop_start_reg <= 1'b1;
            loop_count_reg <= loop_count_reg + 4'd1;
          end
        end
        RUN: begin
          if (!bus.run_en) begin
            state_reg   <= HOLD;
            running_reg <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.run_en) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase

      if (speed_change) begin
        presc_reg <= '0;
      end else if (count_en) begin
        presc_reg <= at_terminal ? '0 : presc_reg + DIV_W'(1);
      end

      // IDLE never advances, so this cannot collide with the IDLE loop_start above.
      if (advance) begin
        tick_reg <= 1'b1;
        if (pos_last) begin
          pos_reg        <= '0;
          loop_start_reg <= 1'b1;
          loop_count_reg <= loop_count_reg + 4'd1;
        end else begin
          pos_reg <= pos_reg + POS_W'(1);
        end
      end
    end
  end

  assign bus.scroll_pos  = pos_reg;
  assign bus.scroll_tick = tick_reg;
  assign bus.loop_start  = loop_start_reg;
  assign bus.loop_count  = loop_count_reg;
  assign bus.running     = running_reg;

endmodule

// File: tb/tb_scroll_loop_sequencer.sv
// Bench for scroll_loop_sequencer: directed scenarios plus random run/hold/speed/step
// traffic, every cycle compared against a reference model built on total advance counts.
module tb_scroll_loop_sequencer;
  localparam int TICK_DIV   = 8;
  localparam int PHRASE_LEN = 4;
  localparam int POS_W      = 3;
  localparam int DIV_W      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scroll_loop_sequencer_if #(.POS_W(POS_W)) bus ();

  scroll_loop_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .PHRASE_LEN(PHRASE_LEN),
    .POS_W     (POS_W),
    .DIV_W     (DIV_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: mode 0=idle 1=run 2=hold; position and loop count derive
  // from the total number of advances and loop starts since reset.
  int m_mode, m_phase, m_adv, m_starts, m_speed;
  bit e_tick, e_ls, prev_ls;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_advance();
    m_adv++;
    e_tick = 1'b1;
    if (m_adv % PHRASE_LEN == 0) begin
      m_starts++;
      e_ls = 1'b1;
    end
  endtask

  task automatic model_edge(input bit r, input bit run, input int spd, input bit step);
    bit changed;
    e_tick = 1'b0;
    e_ls   = 1'b0;
    if (!r) begin
      m_mode = 0; m_phase = 0; m_adv = 0; m_starts = 0; m_speed = spd;
    end else begin
      changed = (spd != m_speed);
      m_speed = spd;
      if (m_mode == 0) begin
        if (run) begin
          m_mode = 1;
          m_starts++;
          e_ls = 1'b1;
        end
      end else if (run) begin
        m_mode = 1;
        if (changed) m_phase = 0;
        else if (m_phase + 1 >= (TICK_DIV >> m_speed)) begin
          m_phase = 0;
          model_advance();
        end else m_phase++;
      end else begin
        if (changed) m_phase = 0;
        if (m_mode == 2 && step) model_advance();
        m_mode = 2;
      end
    end
  endtask

  task automatic compare_outputs();
    check_val("scroll_pos",  bus.scroll_pos,  m_adv % PHRASE_LEN);
    check_val("scroll_tick", bus.scroll_tick, e_tick);
    check_val("loop_start",  bus.loop_start,  e_ls);
    check_val("loop_count",  bus.loop_count,  m_starts % 16);
    check_val("running",     bus.running,     m_mode == 1);
    check_val("loop_start_b2b", prev_ls & bus.loop_start, 0);
    prev_ls = bus.loop_start;
  endtask

  task automatic drive_cycle(input bit r, input bit run, input logic [1:0] spd, input bit step);
    reset         = r;
    bus.run_en    = run;
    bus.speed_sel = spd;
    bus.step_req  = step;
    @(posedge clk);
    model_edge(r, run, int'(spd), step);
    #1;
    compare_outputs();
  endtask

  initial begin
    int n, cnt_before, starts_seen, ticks_seen;
    logic [POS_W-1:0] pos_before;
    logic [3:0] prev_cnt;
    bit seen_15_0, seen_0_1, cur_run, rr, st;
    logic [1:0] cur_spd;

    reset = 1'b0; bus.run_en = 1'b1; bus.speed_sel = 2'd0; bus.step_req = 1'b0;
    prev_ls = 1'b0;
    m_mode = 0; m_phase = 0; m_adv = 0; m_starts = 0; m_speed = 0;
    e_tick = 1'b0; e_ls = 1'b0;

    // 1: reset held with run_en=1, then release
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 2'd0, 1'b0);
    check_val("s1_rst_running", bus.running, 0);
    check_val("s1_rst_count", bus.loop_count, 0);
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    check_val("s1_start_pulse", bus.loop_start, 1);
    check_val("s1_start_count", bus.loop_count, 1);
    check_val("s1_start_running", bus.running, 1);
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    check_val("s1_pulse_width", bus.loop_start, 0);
    $display("[TB] scenario 1: released, loop_count=%0d", bus.loop_count);

    // 2: one full loop at speed 0 (31 more cycles -> 4 ticks total)
    for (int i = 0; i < 31; i++) drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    check_val("s2_pos_wrap", bus.scroll_pos, 0);
    check_val("s2_loop_start", bus.loop_start, 1);
    check_val("s2_loop_count", bus.loop_count, 2);
    $display("[TB] scenario 2: loop done, loop_count=%0d", bus.loop_count);

    // 3: speed 0 -> 3 mid-count
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0);
    check_val("s3_no_tick_on_change", bus.scroll_tick, 0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b1, 2'd3, 1'b0);
      check_val("s3_fast_tick", bus.scroll_tick, 1);
    end
    $display("[TB] scenario 3: fast ticks, pos=%0d", bus.scroll_pos);

    // 4: hold at prescaler 5, step twice, resume
    n = 0;
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    while (m_phase != 5 && n < 20) begin
      drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
      n++;
    end
    ticks_seen = 0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
      ticks_seen += int'(bus.scroll_tick);
    end
    check_val("s4_hold_no_ticks", ticks_seen, 0);
    pos_before = bus.scroll_pos;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 2'd0, 1'b1);
      check_val("s4_step_tick", bus.scroll_tick, 1);
      drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    end
    check_val("s4_step_pos", bus.scroll_pos, (int'(pos_before) + 2) % PHRASE_LEN);
    n = 1;
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    while (bus.scroll_tick !== 1'b1 && n < 20) begin
      drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
      n++;
    end
    check_val("s4_resume_latency", n, 3);
    $display("[TB] scenario 4: resumed after %0d cycles, pos=%0d", n, bus.scroll_pos);

    // 5: run_en=0 and step_req=1 on the same RUN edge, then 17 loops
    pos_before = bus.scroll_pos;
    drive_cycle(1'b1, 1'b0, 2'd0, 1'b1);
    check_val("s5_pos_unchanged", bus.scroll_pos, pos_before);
    check_val("s5_held", bus.running, 0);
    check_val("s5_no_tick", bus.scroll_tick, 0);
    cnt_before = int'(bus.loop_count);
    prev_cnt = bus.loop_count;
    starts_seen = 0; n = 0; seen_15_0 = 1'b0; seen_0_1 = 1'b0;
    while (starts_seen < 17 && n < 400) begin
      drive_cycle(1'b1, 1'b1, 2'd3, 1'b0);
      if (bus.loop_start === 1'b1) starts_seen++;
      if (prev_cnt == 4'd15 && bus.loop_count == 4'd0) seen_15_0 = 1'b1;
      if (prev_cnt == 4'd0 && bus.loop_count == 4'd1) seen_0_1 = 1'b1;
      prev_cnt = bus.loop_count;
      n++;
    end
    check_val("s5_loops_started", starts_seen, 17);
    check_val("s5_count_final", bus.loop_count, (cnt_before + 17) % 16);
    check_val("s5_wrap_15_0", seen_15_0, 1);
    check_val("s5_wrap_0_1", seen_0_1, 1);
    $display("[TB] scenario 5: 17 loops, loop_count=%0d", bus.loop_count);

    // 6: reset mid-RUN at pos=2
    n = 0;
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    while (bus.scroll_pos !== 3'd2 && n < 40) begin
      drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
      n++;
    end
    check_val("s6_reached_pos2", bus.scroll_pos, 2);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd0, 1'b0);
      check_val("s6_rst_pos", bus.scroll_pos, 0);
      check_val("s6_rst_running", bus.running, 0);
      check_val("s6_rst_loop_start", bus.loop_start, 0);
    end
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
    check_val("s6_restart", bus.loop_start, 1);
    $display("[TB] scenario 6: restarted, loop_count=%0d", bus.loop_count);

    // Random traffic against the model
    cur_run = 1'b1;
    cur_spd = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_run = ~cur_run;
      if ($urandom_range(0, 39) == 0) cur_spd = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 149) != 0);
      st = ($urandom_range(0, 5) == 0);
      drive_cycle(rr, cur_run, cur_spd, st);
    end
    $display("[TB] random phase: 1500 cycles, pos=%0d loop_count=%0d", bus.scroll_pos, bus.loop_count);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
